// File: rtl/btn_debouncer.sv
// ============================================================================
//  Module      : btn_debouncer
//  Description : Per-button bounce filter feeding the edge detector. Optional
//                2-flop input synchroniser enabled by BTN_DEBOUNCER_SYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debouncer #(
    parameter int N_BTN         = 4,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_clean,
    output logic [N_BTN-1:0] btn_busy
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] c_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [N_BTN-1:0] w_s;

`ifdef BTN_DEBOUNCER_SYNC_EN
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = btn_raw;
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t        r_state;
        logic [CW-1:0] r_cnt;
        logic          r_clean;

        // Any sample equal to the accepted level restarts qualification.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_clean <= 1'b0;
            end else if (w_s[i] == r_clean) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
            end else if (r_cnt == c_LAST) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_clean <= w_s[i];
            end else begin
                r_state <= ST_CHECK;
                r_cnt   <= r_cnt + CW'(1);
            end
        end

        assign btn_clean[i] = r_clean;
        assign btn_busy[i]  = (r_state == ST_CHECK);
    end

endmodule

`default_nettype wire

// File: doc/btn_debouncer.md
# btn_debouncer

Per-button debouncer that sits directly upstream of the edge detector. It filters mechanical bounce on the raw push-button inputs and presents a clean, level-stable `btn_clean` bus. The edge detector consumes that bus and produces its one-cycle press pulses. It optionally synchronises the asynchronous pad inputs into the `clk` domain first.

## Interface
- `N_BTN`, default 4: number of independent buttons.
- `STABLE_CYCLES`, default 1000000: number of consecutive mismatching samples needed to accept a new level (10 ms at 100 MHz). Legal range is 1 to 2^24.
- `clk` input, 1 bit: single system clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `btn_raw` input, `N_BTN` bits: raw button levels, 1 = pressed.
- `btn_clean` output, `N_BTN` bits: debounced levels; feeds the edge detector's `btn` input.
- `btn_busy` output, `N_BTN` bits: 1 while that button is in the CHECK state.

## Operation
- Every output and internal register is a registered flop.
- Sample `s[i]`:
  - With the synchroniser enabled (see Configuration), `s[i]` is the output of the 2-flop synchroniser.
  - Otherwise `s[i]` is `btn_raw[i]` directly.
- Each button has an independent FSM and counter `cnt[i]`:
  - Counter width is `$clog2(STABLE_CYCLES+1)`.
  - There is no sharing between buttons.
- States:
  - STABLE: `cnt[i]` is 0 and `btn_busy[i]` is 0.
  - CHECK: `cnt[i]` is nonzero and `btn_busy[i]` is 1.
- On each rising edge, per button:
  - **Match** (`s[i] == btn_clean[i]`): `cnt[i]` <= 0 and the FSM goes to STABLE. In CHECK this is a rejected glitch.
  - **Mismatch with `cnt[i] == STABLE_CYCLES-1`**: `btn_clean[i]` <= `s[i]`, `cnt[i]` <= 0, FSM goes to STABLE.
  - **Mismatch otherwise**: `cnt[i]` <= `cnt[i]+1`, FSM goes to CHECK.
- Net effect: `btn_clean[i]` takes a new level on the `STABLE_CYCLES`-th consecutive rising edge at which the sample differs from it. A single matching sample restarts the count.
- `STABLE_CYCLES == 1`: `btn_clean` follows `s` with one register delay, and `btn_busy` is never 1.
- Press and release are filtered symmetrically.
- The counter never exceeds `STABLE_CYCLES-1` and never wraps.
- Simultaneous activity on several buttons is handled fully independently; one button's filtering has no effect on another's.

## Timing
- Reset values while `rst` = 1 at a rising edge:
  - `btn_clean` = 0, `btn_busy` = 0, all `cnt` = 0.
  - Synchroniser flops = 0.
- Reset mid-CHECK discards the partial count. After reset a held button re-qualifies from zero.
- `rst` takes priority over all other updates.
- Latency without the synchroniser:
  - `btn_raw` changes before edge k and stays stable.
  - `btn_clean` changes after edge k+`STABLE_CYCLES`-1.
- Latency with the synchroniser: 2 edges more.
- No input handshake: `btn_raw` may change at any time, and the edge detector samples `btn_clean` every cycle.

## Configuration
- Macro: `BTN_DEBOUNCER_SYNC_EN`.
- **Defined**:
  - `btn_raw[i]` passes through two back-to-back flops clocked by `clk`, both reset to 0.
  - `s[i]` is the second flop.
  - Adds 2 cycles of latency and makes the block safe for asynchronous pad inputs.
- **Undefined**:
  - No synchroniser flops; `s[i] = btn_raw[i]`.
  - `btn_raw` must already be synchronous to `clk`.

## Test plan
All scenarios use `N_BTN`=4 and `STABLE_CYCLES`=4, without the macro unless stated.

- **Reset**: hold `rst` 3 cycles with `btn_raw`=4'b1111 -> `btn_clean`=0 and `btn_busy`=0 throughout; `btn_clean` becomes 4'b1111 exactly 4 edges after `rst` falls.
- **Clean press**: `btn_raw[0]` 0->1 before edge k and held -> `btn_busy[0]`=1 after edges k..k+2; `btn_clean[0]`=1 and `btn_busy[0]`=0 after edge k+3.
- **Bounce rejection**: `btn_raw[1]` pattern 1,1,1,0,1,1,1,1 on successive edges -> `btn_clean[1]` stays 0 through the glitch; it goes to 1 only after the 4th consecutive 1 (8th edge).
- **Simultaneous**: press btn2 and release btn3 (previously clean 1) on the same edge -> both `btn_clean` bits change on the same edge 3 cycles later; btn0 and btn1 are undisturbed.
- **Reset mid-CHECK**: assert `rst` after 2 mismatching edges -> `cnt` cleared and `btn_clean` stays 0; after `rst` deasserts, 4 full edges are required.
- **`BTN_DEBOUNCER_SYNC_EN` defined**: repeat the clean-press scenario -> `btn_clean[0]` rises after edge k+5.
